ex_muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.

---
 rtl/ex_muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: one shift-add or
// restoring shift-subtract step per cycle, fixed latency for every funct3.
module ex_muldiv_unit #(
   parameter int XLEN = 32,
   parameter int ITER = 32
) (
   input  logic            CLK,
   input  logic            reset,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   output logic            stall,
   output logic            result_valid,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(ITER);
   localparam logic [CW-1:0] LAST = CW'(ITER - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [2:0]    funct3_q, funct3_d;
   logic [63:0]   acc_q, acc_d;
   logic [31:0]   opb_q, opb_d;
   logic [31:0]   rem_q, rem_d;
   logic          neg_q, neg_d;
   logic          dz_q, dz_d;
   logic          ovf_q, ovf_d;
   logic [31:0]   result_q, result_d;
   logic          result_valid_q, result_valid_d;

   // Operand conditioning at accept time.
   logic        a_signed, b_signed, neg_a, neg_b;
   logic [31:0] abs_a, abs_b;

   assign a_signed = (funct3 == 3'd1) | (funct3 == 3'd2) | (funct3 == 3'd4) | (funct3 == 3'd6);
   assign b_signed = (funct3 == 3'd1) | (funct3 == 3'd4) | (funct3 == 3'd6);
   assign neg_a    = a_signed & operand_a[31];
   assign neg_b    = b_signed & operand_b[31];
   assign abs_a    = neg_a ? (32'd0 - operand_a) : operand_a;
   assign abs_b    = neg_b ? (32'd0 - operand_b) : operand_b;

   // Multiply: acc holds {partial product, remaining multiplier bits}.
   logic [32:0] mul_sum;
   logic [63:0] mul_next;

   assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
   assign mul_next = {mul_sum, acc_q[31:1]};

   // Divide: acc[31:0] shifts dividend bits out and quotient bits in.
   logic [32:0] div_shift, div_diff;
   logic        div_ge;
   logic [31:0] div_rem_next, div_quo_next;

   assign div_shift    = {rem_q, acc_q[31]};
   assign div_ge       = (div_shift >= {1'b0, opb_q});
   assign div_diff     = div_shift - {1'b0, opb_q};
   assign div_rem_next = 32'(div_ge ? div_diff : div_shift);
   assign div_quo_next = {acc_q[30:0], div_ge};

   logic [63:0] prod_fin;
   logic [31:0] quo_fin, rem_fin, final_res;

   assign prod_fin = neg_q ? (64'd0 - mul_next) : mul_next;
   assign quo_fin  = neg_q ? (32'd0 - div_quo_next) : div_quo_next;
   assign rem_fin  = neg_q ? (32'd0 - div_rem_next) : div_rem_next;

   // A zero divisor leaves |a| in the remainder, so REM/REMU already yield a.
   always_comb begin
      final_res = 32'd0;
      case (funct3_q)
         3'd0:                final_res = prod_fin[31:0];
         3'd1, 3'd2, 3'd3:    final_res = prod_fin[63:32];
         3'd4, 3'd5:          final_res = dz_q ? 32'hFFFF_FFFF : (ovf_q ? 32'h8000_0000 : quo_fin);
         default:             final_res = ovf_q ? 32'd0 : rem_fin;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      count_d        = count_q;
      funct3_d       = funct3_q;
      acc_d          = acc_q;
      opb_d          = opb_q;
      rem_d          = rem_q;
      neg_d          = neg_q;
      dz_d           = dz_q;
      ovf_d          = ovf_q;
      result_d       = result_q;
      result_valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && !flush) begin
               state_d  = S_RUN;
               count_d  = '0;
               funct3_d = funct3;
               acc_d    = {32'd0, funct3[2] ? abs_a : abs_b};
               opb_d    = funct3[2] ? abs_b : abs_a;
               rem_d    = 32'd0;
               neg_d    = (funct3 == 3'd6) ? neg_a : (neg_a ^ neg_b);
               dz_d     = (operand_b == 32'd0);
               ovf_d    = (funct3 == 3'd4 || funct3 == 3'd6) &&
                          (operand_a == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF);
            end
         end
         S_RUN: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               acc_d   = funct3_q[2] ? {32'd0, div_quo_next} : mul_next;
               rem_d   = div_rem_next;
               count_d = count_q + 1'b1;
               if (count_q == LAST) begin
                  state_d        = S_DONE;
                  result_d       = final_res;
                  result_valid_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q        <= S_IDLE;
         count_q        <= '0;
         funct3_q       <= 3'd0;
         acc_q          <= 64'd0;
         opb_q          <= 32'd0;
         rem_q          <= 32'd0;
         neg_q          <= 1'b0;
         dz_q           <= 1'b0;
         ovf_q          <= 1'b0;
         result_q       <= 32'd0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         count_q        <= count_d;
         funct3_q       <= funct3_d;
         acc_q          <= acc_d;
         opb_q          <= opb_d;
         rem_q          <= rem_d;
         neg_q          <= neg_d;
         dz_q           <= dz_d;
         ovf_q          <= ovf_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
      end
   end

   // Combinational so ID/EX already holds during the accept cycle.
   assign stall        = ((state_q == S_IDLE) & start & ~flush) | (state_q == S_RUN);
   assign result_valid = result_valid_q;
   assign result       = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed RV32M cases, flush/reset aborts,
// back-to-back issue and random ops checked against an arithmetic model.
module tb_ex_muldiv_unit;

   logic        CLK = 1'b0;
   logic        reset, start, flush;
   logic [2:0]  funct3;
   logic [31:0] operand_a, operand_b;
   logic        stall, result_valid;
   logic [31:0] result;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] last_res;

   always #5 CLK = ~CLK;

   ex_muldiv_unit dut (
      .CLK          (CLK),
      .reset        (reset),
      .start        (start),
      .flush        (flush),
      .funct3       (funct3),
      .operand_a    (operand_a),
      .operand_b    (operand_b),
      .stall        (stall),
      .result_valid (result_valid),
      .result       (result)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference computed with plain signed/unsigned 64-bit arithmetic.
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint pa, pb;
      logic [63:0] p;
      int sa, sb;
      sa = a;
      sb = b;
      case (f)
         3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
         3'd1: begin pa = longint'(sa); pb = longint'(sb); p = pa * pb; return p[63:32]; end
         3'd2: begin pa = longint'(sa); pb = longint'({32'd0, b}); p = pa * pb; return p[63:32]; end
         3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(sa / sb);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(sa % sb);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Called at a negedge; issues one op and follows it to its result.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
      int k;
      bit stall_ok;
      funct3    = f;
      operand_a = a;
      operand_b = b;
      start     = 1'b1;
      #1 chk({tag, " stall_accept"}, stall, 1);
      @(negedge CLK);
      start    = 1'b0;
      k        = 0;
      stall_ok = 1'b1;
      while (!result_valid && k < 40) begin
         if (!stall) stall_ok = 1'b0;
         @(negedge CLK);
         k++;
      end
      chk({tag, " latency"}, k, 32);
      chk({tag, " result"}, result, exp);
      chk({tag, " stall_run"}, stall_ok, 1);
      chk({tag, " stall_done"}, stall, 0);
      @(negedge CLK);
      chk({tag, " single_pulse"}, result_valid, 0);
      last_res = exp;
   endtask

   initial begin
      int k;
      bit seen;
      logic [2:0] rf;
      logic [31:0] ra, rb;

      reset = 1'b1; start = 1'b0; flush = 1'b0;
      funct3 = 3'd0; operand_a = 32'd0; operand_b = 32'd0;
      last_res = 32'd0;
      repeat (3) @(negedge CLK);
      chk("reset stall", stall, 0);
      chk("reset result_valid", result_valid, 0);
      chk("reset result", result, 0);
      reset = 1'b0;
      @(negedge CLK);

      run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "MUL 7*-3");
      run_op(3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "MULH min*min");
      run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU max*max");
      run_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHSU -1*max");
      run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "DIV -7/2");
      run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "REM -7%2");
      run_op(3'd5, 32'hFFFF_FFFE,  32'd2,         32'h7FFF_FFFF, "DIVU");
      run_op(3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, "DIV by zero");
      run_op(3'd7, 32'd5,          32'd0,         32'd5,         "REMU by zero");
      run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "DIV overflow");
      run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         "REM overflow");

      // Flush ten cycles into a DIV: no result, result register untouched.
      funct3 = 3'd4; operand_a = 32'd1000; operand_b = 32'd3; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      repeat (10) @(negedge CLK);
      flush = 1'b1;
      @(negedge CLK);
      flush = 1'b0;
      chk("flush stall", stall, 0);
      chk("flush result_valid", result_valid, 0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge CLK);
         if (result_valid) seen = 1'b1;
      end
      chk("flush no pulse", seen, 0);
      chk("flush result kept", result, last_res);

      // Reset five cycles into a MUL.
      funct3 = 3'd0; operand_a = 32'd3; operand_b = 32'd5; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      repeat (5) @(negedge CLK);
      reset = 1'b1;
      @(negedge CLK);
      chk("midop reset stall", stall, 0);
      chk("midop reset result_valid", result_valid, 0);
      chk("midop reset result", result, 0);
      reset = 1'b0;
      @(negedge CLK);
      run_op(3'd0, 32'd3, 32'd5, 32'd15, "MUL after reset");

      // start held high: DIVU 100/7 then a MUL presented once DONE ends.
      funct3 = 3'd5; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
      @(negedge CLK);
      k = 0;
      while (!result_valid && k < 40) begin
         @(negedge CLK);
         k++;
      end
      chk("b2b first latency", k, 32);
      chk("b2b first result", result, 14);
      @(negedge CLK);
      chk("b2b single pulse", result_valid, 0);
      funct3 = 3'd0; operand_a = 32'd123; operand_b = 32'd456;
      #1 chk("b2b stall_accept", stall, 1);
      @(negedge CLK);
      start = 1'b0;
      k = 2;
      while (!result_valid && k < 60) begin
         @(negedge CLK);
         k++;
      end
      chk("b2b period", k, 34);
      chk("b2b second result", result, 32'd56088);
      @(negedge CLK);

      for (int i = 0; i < 24; i++) begin
         rf = 3'($urandom_range(0, 7));
         ra = pick();
         rb = pick();
         run_op(rf, ra, rb, model(rf, ra, rb), $sformatf("rand%0d f%0d %h %h", i, rf, ra, rb));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
